// File: rtl/d_ff.sv
// D-type register block: q1 is d delayed by one clock, q2 is d delayed by Q2_STAGES clocks.
// Synchronous active-low reset loads RESET_VAL into q1 and every pipeline stage.
module d_ff #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 Q2_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2
);

  generate
    if (Q2_STAGES < 1 || Q2_STAGES > 16) begin : g_bad_stages
      $error("d_ff: Q2_STAGES must be in 1..16");
    end
  endgenerate

  logic [WIDTH-1:0] stage [Q2_STAGES];

  // Reset clears the whole pipeline in one edge, discarding in-flight data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q1 <= RESET_VAL;
      for (int i = 0; i < Q2_STAGES; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      q1       <= d;
      stage[0] <= d;
      for (int i = 1; i < Q2_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q2 = stage[Q2_STAGES-1];

endmodule

// File: tb/tb_d_ff.sv
// Directed bench for d_ff: table of hand-computed vectors on the default instance,
// plus hand-written sequences for mid-cycle reset and the WIDTH=8/Q2_STAGES=4 instance.
module tb_d_ff;

  logic       clk = 1'b0;
  logic       reset_a;
  logic       d_a;
  logic       q1_a, q2_a;
  logic       reset_p;
  logic [7:0] d_p;
  logic [7:0] q1_p, q2_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  d_ff u_dut_a (
    .clk   (clk),
    .reset (reset_a),
    .d     (d_a),
    .q1    (q1_a),
    .q2    (q2_a)
  );

  d_ff #(.WIDTH(8), .RESET_VAL(8'hA5), .Q2_STAGES(4)) u_dut_p (
    .clk   (clk),
    .reset (reset_p),
    .d     (d_p),
    .q1    (q1_p),
    .q2    (q2_p)
  );

  typedef struct {
    logic rst;
    logic d;
    logic q1;
    logic q2;
  } vec_t;

  vec_t tbl [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rst, d, q1 after edge, q2 after edge
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1};

    reset_a = 1'b0;
    d_a     = 1'b1;
    reset_p = 1'b0;
    d_p     = 8'h3C;

    for (int i = 0; i < 13; i++) begin
      reset_a = tbl[i].rst;
      d_a     = tbl[i].d;
      step();
      check($sformatf("tbl%0d_q1", i), {7'd0, q1_a}, {7'd0, tbl[i].q1});
      check($sformatf("tbl%0d_q2", i), {7'd0, q2_a}, {7'd0, tbl[i].q2});
    end

    // Reset dropped between edges must not touch outputs until the next edge.
    #4;
    reset_a = 1'b0;
    #1;
    check("midcyc_q1_hold", {7'd0, q1_a}, 8'd1);
    check("midcyc_q2_hold", {7'd0, q2_a}, 8'd1);
    step();
    check("midcyc_q1_clr", {7'd0, q1_a}, 8'd0);
    check("midcyc_q2_clr", {7'd0, q2_a}, 8'd0);

    // Data path: d toggles every 5 edges starting from a cleared pipeline.
    reset_a = 1'b1;
    for (int k = 0; k < 50; k++) begin
      d_a = 1'((k / 5) % 2);
      step();
      check($sformatf("dp%0d_q1", k), {7'd0, q1_a}, {7'd0, 1'((k / 5) % 2)});
      check($sformatf("dp%0d_q2", k), {7'd0, q2_a},
            (k == 0) ? 8'd0 : {7'd0, 1'(((k - 1) / 5) % 2)});
    end

    // Reset mid-stream with d held high.
    d_a = 1'b1;
    step();
    step();
    check("ms_pre_q1", {7'd0, q1_a}, 8'd1);
    check("ms_pre_q2", {7'd0, q2_a}, 8'd1);
    reset_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("ms_rst%0d_q1", k), {7'd0, q1_a}, 8'd0);
      check($sformatf("ms_rst%0d_q2", k), {7'd0, q2_a}, 8'd0);
    end
    reset_a = 1'b1;
    step();
    check("ms_rel1_q1", {7'd0, q1_a}, 8'd1);
    check("ms_rel1_q2", {7'd0, q2_a}, 8'd0);
    step();
    check("ms_rel2_q1", {7'd0, q1_a}, 8'd1);
    check("ms_rel2_q2", {7'd0, q2_a}, 8'd1);

    // Wide instance: RESET_VAL=A5, four stages on q2.
    check("p_rst_q1", q1_p, 8'hA5);
    check("p_rst_q2", q2_p, 8'hA5);
    reset_p = 1'b1;
    step();
    check("p_rel1_q1", q1_p, 8'h3C);
    check("p_rel1_q2", q2_p, 8'hA5);
    step();
    check("p_rel2_q2", q2_p, 8'hA5);
    step();
    check("p_rel3_q2", q2_p, 8'hA5);
    step();
    check("p_rel4_q1", q1_p, 8'h3C);
    check("p_rel4_q2", q2_p, 8'h3C);

    // Single-edge reset pulse while streaming; d at the reset edge is ignored.
    d_p = 8'h11;
    step();
    check("p_s11_q1", q1_p, 8'h11);
    check("p_s11_q2", q2_p, 8'h3C);
    reset_p = 1'b0;
    d_p     = 8'h22;
    step();
    check("p_pulse_q1", q1_p, 8'hA5);
    check("p_pulse_q2", q2_p, 8'hA5);
    reset_p = 1'b1;
    d_p     = 8'h33;
    step();
    check("p_f33_q1", q1_p, 8'h33);
    check("p_f33_q2", q2_p, 8'hA5);
    d_p = 8'h44;
    step();
    check("p_f44_q1", q1_p, 8'h44);
    check("p_f44_q2", q2_p, 8'hA5);
    d_p = 8'h55;
    step();
    check("p_f55_q2", q2_p, 8'hA5);
    d_p = 8'h66;
    step();
    check("p_f66_q1", q1_p, 8'h66);
    check("p_f66_q2", q2_p, 8'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
